// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mul/div op encoding, FSM states and constants.
package mips_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiply / restoring divide datapath with sign fix-up.
// MULDIV_SINGLE_CYCLE_MULT_EN: multiply resolved in one step by a full multiplier.
module muldiv_datapath
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            Rst,
  input  logic            load,
  input  logic            step,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            last_c,
  output logic [XLEN-1:0] res_hi_c,
  output logic [XLEN-1:0] res_lo_c
);

  // acc: {partial product, multiplier} for multiply; [XLEN-1:0] = dividend/quotient for divide
  logic [2*XLEN-1:0] acc, nxt_acc;
  logic [XLEN-1:0]   rem, nxt_rem;
  logic [XLEN-1:0]   b_mag;
  logic              s_a, s_b, is_div, div0;
  logic [CNT_W-1:0]  cnt, ld_cnt;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  always_comb begin
    a_neg = op_is_signed(op) & src_a[XLEN-1];
    b_neg = op_is_signed(op) & src_b[XLEN-1];
    a_abs = a_neg ? XLEN'(-src_a) : src_a;
    b_abs = b_neg ? XLEN'(-src_b) : src_b;
`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
    ld_cnt = op_is_div(op) ? CNT_W'(XLEN-1) : '0;
`else
    ld_cnt = CNT_W'(XLEN-1);
`endif
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      acc    <= '0;
      rem    <= '0;
      b_mag  <= '0;
      s_a    <= 1'b0;
      s_b    <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= {XLEN'(0), a_abs};
      rem    <= '0;
      b_mag  <= b_abs;
      s_a    <= a_neg;
      s_b    <= b_neg;
      is_div <= op_is_div(op);
      div0   <= (src_b == '0);
      cnt    <= ld_cnt;
    end else if (step) begin
      acc <= nxt_acc;
      rem <= nxt_rem;
      cnt <= CNT_W'(cnt - 1'b1);
    end
  end

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_diff_bit;

  // One iteration: add-and-shift for multiply, trial-subtract for divide
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    shifted = {rem, acc[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, b_mag};
    nxt_acc = acc;
    nxt_rem = rem;
    if (is_div) begin
      if (!diff[XLEN+1]) begin
        nxt_rem           = diff[XLEN-1:0];
        nxt_acc[XLEN-1:0] = {acc[XLEN-2:0], 1'b1};
      end else begin
        nxt_rem           = shifted[XLEN-1:0];
        nxt_acc[XLEN-1:0] = {acc[XLEN-2:0], 1'b0};
      end
    end else begin
      nxt_acc = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Partial remainder stays below the divisor, so the trial difference never needs bit XLEN
  assign unused_diff_bit = diff[XLEN];

  logic [2*XLEN-1:0] prod_mag, prod;
  logic [XLEN-1:0]   quot, rmd;
  logic              neg;

  always_comb begin
`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
    prod_mag = (2*XLEN)'(acc[XLEN-1:0]) * (2*XLEN)'(b_mag);
`else
    prod_mag = nxt_acc;
`endif
    neg  = s_a ^ s_b;
    prod = neg ? (2*XLEN)'(-prod_mag) : prod_mag;
    quot = nxt_acc[XLEN-1:0];
    rmd  = nxt_rem;
    if (is_div) begin
      res_lo_c = div0 ? DIV0_QUOT : (neg ? XLEN'(-quot) : quot);
      res_hi_c = s_a ? XLEN'(-rmd) : rmd;
    end else begin
      res_lo_c = prod[XLEN-1:0];
      res_hi_c = prod[2*XLEN-1:XLEN];
    end
  end

  assign last_c = (cnt == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle MIPS mul/div unit: control FSM, decoder stall and HI/LO registers.
// MULDIV_SINGLE_CYCLE_MULT_EN selects the one-step multiplier in muldiv_datapath.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Stall,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo
);

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op;
  logic            accept_c, load, step, wr_hilo;
  logic            last_c;
  logic [XLEN-1:0] res_hi_c, res_lo_c;

  assign op       = muldiv_op_t'(Op);
  assign accept_c = (state_q == IDLE) && Start && !Op[2];

  muldiv_datapath u_dp (
    .clk      (clk),
    .Rst      (Rst),
    .load     (load),
    .step     (step),
    .op       (op),
    .src_a    (SrcA),
    .src_b    (SrcB),
    .last_c   (last_c),
    .res_hi_c (res_hi_c),
    .res_lo_c (res_lo_c)
  );

  always_ff @(posedge clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wr_hilo = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last_c) begin
          wr_hilo = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE deliberately excluded so a lingering Start cannot retrigger
  assign Stall = !Rst && (accept_c || (state_q == BUSY));

  always_ff @(posedge clk) begin
    if (Rst) begin
      Hi <= '0;
      Lo <= '0;
    end else if (wr_hilo) begin
      Hi <= res_hi_c;
      Lo <= res_lo_c;
    end else if ((state_q == IDLE) && Start) begin
      if (op == OP_MTHI) Hi <= SrcA;
      if (op == OP_MTLO) Lo <= SrcA;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed mul/div/MTxx vectors, reset abort.
module tb_muldiv_unit;
  import mips_pkg::*;

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  logic        clk = 1'b0;
  logic        Rst, Start;
  logic [2:0]  Op;
  logic [31:0] SrcA, SrcB;
  logic        Stall;
  logic [31:0] Hi, Lo;

  muldiv_unit dut (
    .clk   (clk),
    .Rst   (Rst),
    .Start (Start),
    .Op    (Op),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Stall (Stall),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result is due whenever Stall falls outside reset
  initial begin
    logic prev_stall;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!Rst && prev_stall && !Stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got Hi=%h Lo=%h with empty scoreboard", Hi, Lo);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " Hi"}, 64'(Hi), 64'(e.hi));
          check({e.name, " Lo"}, 64'(Lo), 64'(e.lo));
        end
      end
      prev_stall = Stall && !Rst;
    end
  end

  // Issue one mul/div, hold Start like the decoder does until Stall drops
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int exp_cyc);
    exp_t e;
    int n;
    e.name = name;
    e.hi   = hi;
    e.lo   = lo;
    exp_q.push_back(e);
    @(negedge clk);
    Start = 1'b1;
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    #1;
    n = 0;
    while (Stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({name, " stall_cycles"}, 64'(n), 64'(exp_cyc));
    Start = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    Rst   = 1'b1;
    Start = 1'b0;
    Op    = 3'd0;
    SrcA  = '0;
    SrcB  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset Hi", 64'(Hi), 64'h0);
    check("reset Lo", 64'(Lo), 64'h0);
    check("reset Stall", 64'(Stall), 64'h0);
    Rst = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_CYC);
    run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_CYC);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_CYC);
    run_op("divu_by0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_CYC);
    run_op("div_neg_by0", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_CYC);

    // MTHI then MTLO back to back
    @(negedge clk);
    Start = 1'b1;
    Op    = 3'd4;
    SrcA  = 32'h1234_5678;
    #1;
    check("mthi Stall", 64'(Stall), 64'h0);
    @(negedge clk);
    Op   = 3'd5;
    SrcA = 32'h9ABC_DEF0;
    #1;
    check("mthi Hi", 64'(Hi), 64'h1234_5678);
    check("mtlo Stall", 64'(Stall), 64'h0);
    @(negedge clk);
    Op   = 3'd6;
    SrcA = 32'hDEAD_BEEF;
    #1;
    check("mtlo Lo", 64'(Lo), 64'h9ABC_DEF0);
    check("op6 Stall", 64'(Stall), 64'h0);
    @(negedge clk);
    Start = 1'b0;
    #1;
    check("op6 Hi kept", 64'(Hi), 64'h1234_5678);
    check("op6 Lo kept", 64'(Lo), 64'h9ABC_DEF0);

    // Abort a DIVU with reset in cycle 10
    @(negedge clk);
    Start = 1'b1;
    Op    = 3'd3;
    SrcA  = 32'd100;
    SrcB  = 32'd7;
    repeat (10) @(negedge clk);
    Rst = 1'b1;
    #1;
    check("rst_abort Stall_in_rst", 64'(Stall), 64'h0);
    @(negedge clk);
    Rst   = 1'b0;
    Start = 1'b0;
    #1;
    check("rst_abort Hi", 64'(Hi), 64'h0);
    check("rst_abort Lo", 64'(Lo), 64'h0);
    check("rst_abort Stall", 64'(Stall), 64'h0);
    check("rst_abort state", 64'(dut.state_q), 64'(IDLE));

    run_op("multu_3x4", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, MUL_CYC);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
